// File: rtl/battleship_param_pkg.sv
// battleship_pkg: shared state encoding and seven-segment glyph constants
package battleship_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_SHOW_A, S_A_IN, S_ERR_A, S_SHOW_B, S_B_IN, S_ERR_B, S_SHOW_SCORE,
        S_A_SHOOT, S_A_RES, S_B_SHOOT, S_B_RES, S_A_WIN, S_B_WIN, S_SERR_A, S_SERR_B
    } state_t;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_A     = 8'h77;
    localparam logic [7:0] SEG_B     = 8'h7C;
    localparam logic [7:0] SEG_E     = 8'h79;
    localparam logic [7:0] SEG_R     = 8'h50;
    localparam logic [7:0] SEG_O     = 8'h5C;
    localparam logic [7:0] SEG_I     = 8'h06;
    localparam logic [7:0] SEG_D     = 8'h5E;
    localparam logic [7:0] SEG_L     = 8'h38;
    localparam logic [9:0][7:0] GLYPHS = {
        8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };
endpackage

// File: rtl/battleship_param_if.sv
// battleship_param_if: board-side switches/buttons in, seven-segment digits and LEDs out
interface battleship_param_if #(parameter int GRID_BITS = 2);
    logic                 start;
    logic [GRID_BITS-1:0] X;
    logic [GRID_BITS-1:0] Y;
    logic                 pAb;
    logic                 pBb;
    logic [7:0]           disp3;
    logic [7:0]           disp2;
    logic [7:0]           disp1;
    logic [7:0]           disp0;
    logic [7:0]           led;
    modport master (output start, X, Y, pAb, pBb, input disp3, disp2, disp1, disp0, led);
    modport slave  (input start, X, Y, pAb, pBb, output disp3, disp2, disp1, disp0, led);
endinterface

// File: rtl/battleship_param_seg7_digit.sv
// seg7_digit: 4-bit value to dp,g..a glyph; values above 9 show blank
module seg7_digit
    import battleship_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [7:0] o_seg
);
    assign o_seg = (i_val < 4'd10) ? GLYPHS[i_val] : SEG_BLANK;
endmodule

// File: rtl/battleship_param.sv
// battleship_param: two-player battleship controller; BATTLESHIP_SHOT_MEM_EN rejects repeat shots
module battleship_param
    import battleship_pkg::*;
#(
    parameter int GRID_BITS = 2,
    parameter int SHIPS     = 4,
    parameter int WIN_SCORE = 4,
    parameter int TICKS     = 50
) (
    input  logic              clk,
    input  logic              rst,
    battleship_param_if.slave bus
);
    localparam int CELLS = 1 << (2 * GRID_BITS);
    localparam int IW    = 2 * GRID_BITS;
    localparam int TW    = $clog2(TICKS);
    localparam logic [3:0] SHIPS_C = 4'(SHIPS);
    localparam logic [3:0] WIN_C   = 4'(WIN_SCORE);

    state_t           r_state;
    logic [CELLS-1:0] r_map_a, r_map_b;
    logic [3:0]       r_cnt_a, r_cnt_b, r_score_a, r_score_b;
    logic [TW-1:0]    r_timer;
    logic             r_hit;
    logic [IW-1:0]    w_idx;
    logic             w_done, w_timed, w_rep_a, w_rep_b;
    logic [7:0]       w_seg_x, w_seg_y, w_seg_sa, w_seg_sb;
    logic [7:0]       w_d3, w_d2, w_d1, w_d0, w_led;

    assign w_idx   = {bus.Y, bus.X};
    assign w_done  = r_timer == TW'(TICKS - 1);
    assign w_timed = !(r_state inside {S_IDLE, S_A_IN, S_B_IN, S_A_SHOOT, S_B_SHOOT});

`ifdef BATTLESHIP_SHOT_MEM_EN
    logic [CELLS-1:0] r_fired_a, r_fired_b;
    assign w_rep_a = r_fired_a[w_idx];
    assign w_rep_b = r_fired_b[w_idx];
    // remember every accepted shot so a repeat can be refused without consuming the turn
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fired_a <= '0;
            r_fired_b <= '0;
        end else begin
            if (r_state == S_A_SHOOT && bus.pAb && !w_rep_a) r_fired_a[w_idx] <= 1'b1;
            if (r_state == S_B_SHOOT && bus.pBb && !w_rep_b) r_fired_b[w_idx] <= 1'b1;
        end
    end
`else
    assign w_rep_a = 1'b0;
    assign w_rep_b = 1'b0;
`endif

    seg7_digit u_seg_x  (.i_val(4'(bus.X)), .o_seg(w_seg_x));
    seg7_digit u_seg_y  (.i_val(4'(bus.Y)), .o_seg(w_seg_y));
    seg7_digit u_seg_sa (.i_val(r_score_a), .o_seg(w_seg_sa));
    seg7_digit u_seg_sb (.i_val(r_score_b), .o_seg(w_seg_sb));

    // game sequencing: timed states hold TICKS cycles, input states wait on the active player's button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_map_a   <= '0;
            r_map_b   <= '0;
            r_cnt_a   <= '0;
            r_cnt_b   <= '0;
            r_score_a <= '0;
            r_score_b <= '0;
            r_timer   <= '0;
            r_hit     <= 1'b0;
        end else begin
            r_timer <= (w_timed && !w_done) ? r_timer + 1'b1 : '0;
            case (r_state)
                S_IDLE:       if (bus.start) r_state <= S_SHOW_A;
                S_SHOW_A:     if (w_done) r_state <= S_A_IN;
                S_ERR_A:      if (w_done) r_state <= S_A_IN;
                S_SHOW_B:     if (w_done) r_state <= S_B_IN;
                S_ERR_B:      if (w_done) r_state <= S_B_IN;
                S_SHOW_SCORE: if (w_done) r_state <= S_A_SHOOT;
                S_SERR_A:     if (w_done) r_state <= S_A_SHOOT;
                S_SERR_B:     if (w_done) r_state <= S_B_SHOOT;
                S_A_RES:      if (w_done) r_state <= (r_score_a == WIN_C) ? S_A_WIN : S_B_SHOOT;
                S_B_RES:      if (w_done) r_state <= (r_score_b == WIN_C) ? S_B_WIN : S_A_SHOOT;
                S_A_IN: if (bus.pAb) begin
                    if (r_map_a[w_idx]) r_state <= S_ERR_A;
                    else begin
                        r_map_a[w_idx] <= 1'b1;
                        r_cnt_a        <= r_cnt_a + 4'd1;
                        if (r_cnt_a + 4'd1 == SHIPS_C) r_state <= S_SHOW_B;
                    end
                end
                S_B_IN: if (bus.pBb) begin
                    if (r_map_b[w_idx]) r_state <= S_ERR_B;
                    else begin
                        r_map_b[w_idx] <= 1'b1;
                        r_cnt_b        <= r_cnt_b + 4'd1;
                        if (r_cnt_b + 4'd1 == SHIPS_C) r_state <= S_SHOW_SCORE;
                    end
                end
                S_A_SHOOT: if (bus.pAb) begin
                    if (w_rep_a) r_state <= S_SERR_A;
                    else begin
                        r_hit   <= r_map_b[w_idx];
                        r_state <= S_A_RES;
                        if (r_map_b[w_idx]) begin
                            r_map_b[w_idx] <= 1'b0;
                            r_score_a      <= (r_score_a < WIN_C) ? r_score_a + 4'd1 : r_score_a;
                        end
                    end
                end
                S_B_SHOOT: if (bus.pBb) begin
                    if (w_rep_b) r_state <= S_SERR_B;
                    else begin
                        r_hit   <= r_map_a[w_idx];
                        r_state <= S_B_RES;
                        if (r_map_a[w_idx]) begin
                            r_map_a[w_idx] <= 1'b0;
                            r_score_b      <= (r_score_b < WIN_C) ? r_score_b + 4'd1 : r_score_b;
                        end
                    end
                end
                S_A_WIN, S_B_WIN: r_state <= r_state;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // display and LED decode from the current state and game registers
    always_comb begin
        w_d3  = SEG_BLANK;
        w_d2  = SEG_BLANK;
        w_d1  = SEG_BLANK;
        w_d0  = SEG_BLANK;
        w_led = 8'h00;
        case (r_state)
            S_IDLE: begin
                {w_d3, w_d2, w_d1, w_d0} = {SEG_I, SEG_D, SEG_L, SEG_E};
                w_led = 8'h99;
            end
            S_SHOW_A: w_d3 = SEG_A;
            S_SHOW_B: w_d3 = SEG_B;
            S_A_IN: begin
                {w_d1, w_d0} = {w_seg_x, w_seg_y};
                w_led = {1'b1, r_cnt_a[2:0], 4'b0000};
            end
            S_B_IN: begin
                {w_d1, w_d0} = {w_seg_x, w_seg_y};
                w_led = {4'b0000, r_cnt_b[2:0], 1'b1};
            end
            S_ERR_A, S_ERR_B, S_SERR_A, S_SERR_B: begin
                {w_d3, w_d2, w_d1, w_d0} = {SEG_E, SEG_R, SEG_R, SEG_O};
                w_led = 8'h99;
            end
            S_SHOW_SCORE: begin
                {w_d3, w_d2, w_d1, w_d0} = {GLYPHS[0], SEG_DASH, SEG_DASH, GLYPHS[0]};
                w_led = 8'h99;
            end
            S_A_SHOOT: begin
                {w_d1, w_d0} = {w_seg_x, w_seg_y};
                w_led = {1'b1, r_score_a[2:0], r_score_b[2:0], 1'b0};
            end
            S_B_SHOOT: begin
                {w_d1, w_d0} = {w_seg_x, w_seg_y};
                w_led = {1'b0, r_score_a[2:0], r_score_b[2:0], 1'b1};
            end
            S_A_RES, S_B_RES: begin
                {w_d3, w_d2, w_d1, w_d0} = {w_seg_sa, SEG_DASH, SEG_DASH, w_seg_sb};
                w_led = r_hit ? 8'hFF : 8'h00;
            end
            S_A_WIN, S_B_WIN: begin
                {w_d3, w_d2, w_d1, w_d0} = {(r_state == S_A_WIN) ? SEG_A : SEG_B, w_seg_sa, SEG_DASH, w_seg_sb};
                w_led = (r_timer < TW'(TICKS / 2)) ? 8'hFF : 8'h00;
            end
            default: w_led = 8'h00;
        endcase
    end

    assign bus.disp3 = w_d3;
    assign bus.disp2 = w_d2;
    assign bus.disp1 = w_d1;
    assign bus.disp0 = w_d0;
    assign bus.led   = w_led;
endmodule

// File: tb/tb_battleship_param.sv
// tb_battleship_param: randomized game play against a game-rule reference model
module tb_battleship_param;
    localparam int TICKS = 50;
    localparam int SHIPS = 4;
    localparam int WIN   = 4;
    localparam logic [31:0] IDLE_D = 32'h065E3879;
    localparam logic [31:0] ERR_D  = 32'h7950505C;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    battleship_param_if #(.GRID_BITS(2)) bus ();
    battleship_param #(.GRID_BITS(2), .SHIPS(SHIPS), .WIN_SCORE(WIN), .TICKS(TICKS)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    logic [31:0] disp;
    assign disp = {bus.disp3, bus.disp2, bus.disp1, bus.disp0};

    int n_pass = 0;
    int n_chk  = 0;
    bit mp[2][16];
    bit fd[2][16];
    int cnt[2];
    int sc[2];
    int turn;
    logic [7:0] glyph [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] coord(input int x, input int y);
        return {16'h0000, glyph[x], glyph[y]};
    endfunction

    function automatic logic [7:0] in_led(input int p);
        return (p == 0) ? 8'(8'h80 | (cnt[0] << 4)) : 8'(8'h01 | (cnt[1] << 1));
    endfunction

    function automatic logic [7:0] shoot_led(input int p);
        return {p == 0, 3'(sc[0]), 3'(sc[1]), p == 1};
    endfunction

    task automatic press(input int p);
        if (p == 0) bus.pAb = 1'b1;
        else bus.pBb = 1'b1;
        @(posedge clk);
        #1;
        bus.pAb = 1'b0;
        bus.pBb = 1'b0;
        @(negedge clk);
    endtask

    task automatic hold(output int n);
        logic [31:0] v;
        v = disp;
        n = 0;
        while (disp === v && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic place(input int p, input int x, input int y);
        int idx, n;
        bus.X = 2'(x);
        bus.Y = 2'(y);
        idx = y * 4 + x;
        press(p);
        if (mp[p][idx]) begin
            chk("place_err", disp, ERR_D);
            chk("place_err_led", bus.led, 8'h99);
            hold(n);
            chk("place_err_len", n, TICKS);
            chk("place_err_back", disp, coord(x, y));
            chk("place_err_cnt", bus.led, in_led(p));
        end else begin
            mp[p][idx] = 1'b1;
            cnt[p]++;
            if (cnt[p] == SHIPS && p == 0) begin
                chk("show_b", disp, 32'h7C000000);
                hold(n);
                chk("show_b_len", n, TICKS);
                chk("b_in", disp, coord(x, y));
                chk("b_in_led", bus.led, in_led(1));
            end else if (cnt[p] == SHIPS) begin
                chk("show_score", disp, 32'h3F40403F);
                chk("show_score_led", bus.led, 8'h99);
                hold(n);
                chk("show_score_len", n, TICKS);
                chk("a_shoot", disp, coord(x, y));
                chk("a_shoot_led", bus.led, shoot_led(0));
            end else chk("place_cnt", bus.led, in_led(p));
        end
    endtask

    task automatic fire(input int p, input int x, input int y);
        int idx, n, q;
        bit hit;
        bus.X = 2'(x);
        bus.Y = 2'(y);
        idx = y * 4 + x;
        q = 1 - p;
        press(p);
`ifdef BATTLESHIP_SHOT_MEM_EN
        if (fd[p][idx]) begin
            chk("repeat_err", disp, ERR_D);
            hold(n);
            chk("repeat_err_len", n, TICKS);
            chk("repeat_back", disp, coord(x, y));
            chk("repeat_led", bus.led, shoot_led(p));
            turn = p;
            return;
        end
`endif
        fd[p][idx] = 1'b1;
        hit = mp[q][idx];
        if (hit) begin
            mp[q][idx] = 1'b0;
            if (sc[p] < WIN) sc[p]++;
        end
        chk("res_disp", disp, {glyph[sc[0]], 8'h40, 8'h40, glyph[sc[1]]});
        chk("res_led", bus.led, hit ? 8'hFF : 8'h00);
        hold(n);
        chk("res_len", n, TICKS);
        if (sc[p] == WIN) begin
            chk("win_disp", disp, {(p == 0) ? 8'h77 : 8'h7C, glyph[sc[0]], 8'h40, glyph[sc[1]]});
            turn = -1;
        end else begin
            chk("next_shoot", disp, coord(x, y));
            chk("next_shoot_led", bus.led, shoot_led(q));
            turn = q;
        end
    endtask

    function automatic int pick_ship();
        for (int i = 0; i < 16; i++) if (mp[1][i]) return i;
        return 0;
    endfunction

    function automatic int pick_miss();
        int idx;
        for (int t = 0; t < 200; t++) begin
            idx = $urandom_range(0, 15);
            if (!mp[0][idx] && !fd[1][idx]) return idx;
        end
        for (int i = 0; i < 16; i++) if (!mp[0][i] && !fd[1][i]) return i;
        return 0;
    endfunction

    initial begin
        int n, idx, errs;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.X = '0;
        bus.Y = '0;
        bus.pAb = 1'b0;
        bus.pBb = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_disp", disp, IDLE_D);
        chk("reset_led", bus.led, 8'h99);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_hold", disp, IDLE_D);

        bus.X = 2'd2;
        bus.Y = 2'd1;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("show_a", disp, 32'h77000000);
        hold(n);
        chk("show_a_len", n, TICKS);
        chk("a_in_coord", disp, 32'h00005B06);
        chk("a_in_led", bus.led, 8'h80);

        place(0, 0, 0);
        place(0, 0, 0);
        bus.X = 2'd3;
        press(1);
        chk("a_in_gate_b", bus.led, in_led(0));
        for (int i = 0; i < 40 && cnt[0] < SHIPS; i++) place(0, $urandom_range(0, 3), $urandom_range(0, 3));
        for (int i = 0; i < 40 && cnt[1] < SHIPS; i++) place(1, $urandom_range(0, 3), $urandom_range(0, 3));

        idx = pick_ship();
        fire(0, idx % 4, idx / 4);
        idx = pick_miss();
        fire(1, idx % 4, idx / 4);
        bus.X = 2'd3;
        bus.Y = 2'd3;
        press(1);
        chk("a_shoot_gate_b", disp, coord(3, 3));
        chk("a_shoot_gate_b_led", bus.led, shoot_led(0));
        fire(0, 1, 1);
        idx = pick_miss();
        fire(1, idx % 4, idx / 4);
        fire(0, 1, 1);

        for (int i = 0; i < 40 && turn >= 0; i++) begin
            if (turn == 0) idx = pick_ship();
            else idx = pick_miss();
            fire(turn, idx % 4, idx / 4);
        end
        chk("game_won", turn, -1);

        errs = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.led !== (((i % 50) < 25) ? 8'hFF : 8'h00)) errs++;
            @(negedge clk);
        end
        chk("win_blink_errs", errs, 0);
        repeat ($urandom_range(1, 40)) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_disp", disp, IDLE_D);
        chk("async_rst_led", bus.led, 8'h99);
        @(negedge clk);
        rst = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/battleship_param.md
Name: battleship_param

Overview:
- Parametrised two-player battleship game controller. Grid size, ship count, win score and display-hold time are all configurable.
- Sits between the debounced board I/O (switches X/Y, buttons pAb/pBb, start) and four seven-segment digits plus 8 LEDs.
- Adds two behaviours over the fixed 4x4 game: a configurable win threshold, and optional repeat-shot rejection.

Parameters:
- GRID_BITS, 2: coordinate width; grid is 2^GRID_BITS square; legal range 1..3.
- SHIPS, 4: ships each player places; legal range 1..min(9, 4^GRID_BITS).
- WIN_SCORE, 4: hits needed to win; legal range 1..SHIPS.
- TICKS, 50: clock cycles per display hold (1 s at 50 Hz); must be at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  level; begins the game from IDLE
- X  in  GRID_BITS  column select
- Y  in  GRID_BITS  row select
- pAb  in  1  player A button, one-cycle pulse
- pBb  in  1  player B button, one-cycle pulse
- disp3..disp0  out  8 each  seven-segment digits, bit order dp,g..a; dp always 0
- led  out  8  status LEDs

Behaviour:
- Reset: rst is asynchronous, active-high, on clock clk. It clears both maps, counts, scores, timer and hit flag, and forces IDLE.
- Outputs are a combinational decode of state and registers.
- Output values in reset/IDLE: disp3=0x06, disp2=0x5E, disp1=0x38, disp0=0x79 ("IdLE"); led=0x99.
- Cell index = Y*2^GRID_BITS + X. Maps are 4^GRID_BITS bits per player.
- Timer: cleared on entry to every timed state. The state exits after exactly TICKS cycles in it. In WIN states the timer wraps at TICKS-1.
- IDLE -> SHOW_A when start=1.
- SHOW_A: disp3='A', other digits blank; after TICKS cycles -> A_IN.
- A_IN: disp1=X digit, disp0=Y digit, disp3/disp2 blank. led[7]=1, led[6:4]=A placed count[2:0].
  - pAb on a free cell: set the map bit and increment the count. If the new count equals SHIPS -> SHOW_B on the same edge.
  - pAb on an occupied cell: go to ERR_A; map and count unchanged.
- ERR_A: display "Erro" (0x79,0x50,0x50,0x5C), led=0x99; after TICKS cycles -> A_IN.
- SHOW_B, B_IN, ERR_B mirror the A states using pBb. In B_IN, led[0]=1 and led[3:1]=B placed count[2:0]. B_IN exits to SHOW_SCORE.
- SHOW_SCORE: display "0--0", led=0x99; after TICKS cycles -> A_SHOOT.
- A_SHOOT: coordinate display as in A_IN. led[7]=1, led[6:4]=A score[2:0], led[3:1]=B score[2:0].
  - pAb latches hit = B_map[idx]. On a hit: clear the bit and increment A score.
  - Every pAb press -> A_RES.
- A_RES: display "a--b" (A score, '-', '-', B score); led=0xFF if hit else 0x00.
  - After TICKS cycles: if A score == WIN_SCORE -> A_WIN, else -> B_SHOOT.
- B_SHOOT and B_RES mirror A_SHOOT/A_RES with pBb and A_map. B_RES exits to A_SHOOT or B_WIN.
- A_WIN/B_WIN: disp3='A'/'b', disp2=A score, disp1='-', disp0=B score.
  - led=0xFF while timer<TICKS/2, else 0x00; repeats forever until rst.
- Button gating: only the active player's button is honoured. The other button, and any press in non-input states, is ignored. pAb and pBb together count as the active player's press only.
- start is ignored outside IDLE.
- Scores saturate at WIN_SCORE.
- A rst assertion mid-game (any state, any timer value) returns to IDLE on the asynchronous edge.

Optional Feature:
- Macro: BATTLESHIP_SHOT_MEM_EN.
- Defined:
  - Each player keeps a fired-cell map, cleared at reset.
  - Firing at a cell already fired by that player -> SERR_A/SERR_B: "Erro" for TICKS cycles, then back to the same SHOOT state. The turn is not consumed, and score and maps are unchanged.
  - Every valid shot sets its fired bit.
- Undefined: no fired map. Repeat shots are legal misses that consume the turn (go to A_RES/B_RES with hit=0).

Decomposition:
- Package battleship_pkg holds:
  - the state enum;
  - segment constants: blank, dash, A, b, E, r, o, I, d, L;
  - the digit glyph table 0-9.
- One sub-module: seg7_digit, a 4-bit value to 8-bit glyph decode, instantiated for coordinate and score digits.

Test Plan:
- rst, start=1 -> SHOW_A ("A" on disp3) held exactly 50 cycles, then A_IN with X=2,Y=1 shown as disp1=0x5B, disp0=0x06.
- A places (0,0) twice -> ERR_A ("Erro", led=0x99) for 50 cycles, then A_IN with count still 1, led[6:4]=001.
- A places 4 distinct cells -> SHOW_B on the 4th press edge. B places 4 cells -> SHOW_SCORE "0--0" -> A_SHOOT.
- A fires on a B ship -> A_RES, led=0xFF, disp3=0x06. A fires on a miss -> led=0x00. Pressing pBb during A_SHOOT has no effect.
- A scores 4 hits -> A_WIN "A4-b"; led toggles 0xFF/0x00 every 25 cycles. rst mid-blink -> IDLE outputs.
- With BATTLESHIP_SHOT_MEM_EN, A re-fires on (1,1) -> "Erro" 50 cycles, returns to A_SHOOT, scores unchanged. Without the macro the same stimulus -> A_RES miss, then B_SHOOT.
